// File: rtl/uncache_wbuf.sv
// Posted write buffer for uncached stores; drains in order as single-beat AXI writes.
// Optional store merging into the tail-most pending entry is enabled by defining WBUF_MERGE_EN.
module uncache_wbuf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_strb,
    input  logic [2:0]  req_size,
    input  logic [31:0] chk_addr,
    output logic        chk_hit,
    output logic        empty,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RESP} state_t;

    state_t           r_state;
    logic [31:0]      r_mem_addr [DEPTH];
    logic [31:0]      r_mem_data [DEPTH];
    logic [3:0]       r_mem_strb [DEPTH];
    logic [2:0]       r_mem_size [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_aw_done, r_w_done;
    logic             r_awvalid, r_wvalid, r_bready;
    logic [31:0]      r_awaddr, r_wdata;
    logic [3:0]       r_wstrb;
    logic [2:0]       r_awsize;

    logic             w_full, w_push, w_alloc, w_pop;
    logic             w_aw_hs, w_w_hs, w_hit;
    logic [PTR_W-1:0] w_idx, w_off;
    logic [31:0]      w_head_data;
    logic [3:0]       w_head_strb;
    logic             w_unused;

    assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign w_push   = req_valid & req_ready;
    assign w_pop    = (r_state == S_RESP) & bvalid;
    assign w_aw_hs  = r_awvalid & awready;
    assign w_w_hs   = r_wvalid & wready;
    assign w_unused = ^chk_addr[1:0];

`ifdef WBUF_MERGE_EN
    logic [PTR_W-1:0] w_last;
    logic             w_merge;
    logic [31:0]      w_mrg_data;
    logic [3:0]       w_mrg_strb;

    assign w_last  = r_tail - 1'b1;
    assign w_merge = (r_count != '0) && (r_mem_addr[w_last] == req_addr) &&
                     (r_mem_size[w_last] == req_size) &&
                     ((r_state == S_IDLE) || (w_last != r_head));

    always_comb begin
        w_mrg_data = r_mem_data[w_last];
        w_mrg_strb = r_mem_strb[w_last] | req_strb;
        for (int unsigned b = 0; b < 4; b++) begin
            if (req_strb[b]) w_mrg_data[8*b +: 8] = req_data[8*b +: 8];
        end
    end

    assign req_ready = ~w_full | w_merge;
    assign w_alloc   = w_push & ~w_merge;
    // A merge into the head on the very edge it launches must reach the AXI registers too.
    assign w_head_data = (w_push && w_merge && (w_last == r_head)) ? w_mrg_data : r_mem_data[r_head];
    assign w_head_strb = (w_push && w_merge && (w_last == r_head)) ? w_mrg_strb : r_mem_strb[r_head];
`else
    assign req_ready   = ~w_full;
    assign w_alloc     = w_push;
    assign w_head_data = r_mem_data[r_head];
    assign w_head_strb = r_mem_strb[r_head];
`endif

    always_ff @(posedge aclk) begin
        if (w_alloc) begin
            r_mem_addr[r_tail] <= req_addr;
            r_mem_data[r_tail] <= req_data;
            r_mem_strb[r_tail] <= req_strb;
            r_mem_size[r_tail] <= req_size;
        end
`ifdef WBUF_MERGE_EN
        else if (w_push) begin
            r_mem_data[w_last] <= w_mrg_data;
            r_mem_strb[w_last] <= w_mrg_strb;
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) r_tail <= r_tail + 1'b1;
            if (w_pop)   r_head <= r_head + 1'b1;
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_awsize  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_awaddr  <= r_mem_addr[r_head];
                        r_awsize  <= r_mem_size[r_head];
                        r_wdata   <= w_head_data;
                        r_wstrb   <= w_head_strb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // An entry is live when its distance from head is below the count.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = PTR_W'(i);
            w_off = w_idx - r_head;
            if (({1'b0, w_off} < r_count) && (r_mem_addr[w_idx][31:2] == chk_addr[31:2]))
                w_hit = 1'b1;
        end
    end

    assign chk_hit = w_hit;
    assign empty   = (r_count == '0) && (r_state == S_IDLE);
    assign awaddr  = r_awaddr;
    assign awlen   = 4'd0;
    assign awsize  = r_awsize;
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;
endmodule

// File: tb/tb_uncache_wbuf.sv
// Directed self-checking bench for uncache_wbuf; merge steps are built only with WBUF_MERGE_EN.
module tb_uncache_wbuf;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data, chk_addr;
    logic [3:0]  req_strb;
    logic [2:0]  req_size;
    logic        chk_hit, empty;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;
    int aw_hs = 0;
    int w_hs = 0;

    uncache_wbuf #(.DEPTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_strb(req_strb), .req_size(req_size),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (awvalid && awready) aw_hs++;
        if (wvalid && wready) w_hs++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] sz);
        req_addr  = a;
        req_data  = d;
        req_strb  = s;
        req_size  = sz;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_a [4];
        int n, pops, base_aw, base_w;
        logic drop;

        req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0; req_size = '0;
        chk_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        #1 aresetn = 1'b0;
        #2;
        check("rst_awvalid", {31'b0, awvalid}, 32'd0);
        check("rst_wvalid", {31'b0, wvalid}, 32'd0);
        check("rst_bready", {31'b0, bready}, 32'd0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_chk_hit", {31'b0, chk_hit}, 32'd0);
        step(2);
        aresetn = 1'b1;
        step();

        // Single store with an always-ready slave
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        push(32'h1FAF_F000, 32'hDEAD_BEEF, 4'hF, 3'd2);
        check("s1_empty_after_push", {31'b0, empty}, 32'd0);
        check("s1_awvalid_c1", {31'b0, awvalid}, 32'd0);
        step();
        check("s1_awvalid_c2", {31'b0, awvalid}, 32'd1);
        check("s1_wvalid_c2", {31'b0, wvalid}, 32'd1);
        check("s1_awaddr", awaddr, 32'h1FAF_F000);
        check("s1_wdata", wdata, 32'hDEAD_BEEF);
        check("s1_wstrb", {28'b0, wstrb}, 32'hF);
        check("s1_wlast", {31'b0, wlast}, 32'd1);
        check("s1_awsize", {29'b0, awsize}, 32'd2);
        check("s1_awlen", {28'b0, awlen}, 32'd0);
        step();
        check("s1_awvalid_c3", {31'b0, awvalid}, 32'd0);
        check("s1_wvalid_c3", {31'b0, wvalid}, 32'd0);
        check("s1_bready_c3", {31'b0, bready}, 32'd1);
        step();
        check("s1_bready_c4", {31'b0, bready}, 32'd0);
        check("s1_empty_c4", {31'b0, empty}, 32'd1);

        // Fill and back-pressure, pointers wrap
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        exp_a[0] = 32'h1000_0000; exp_a[1] = 32'h1000_0004;
        exp_a[2] = 32'h1000_0008; exp_a[3] = 32'h1000_000C;
        for (int k = 0; k < 4; k++) begin
            check("fill_ready_before_push", {31'b0, req_ready}, 32'd1);
            push(exp_a[k], 32'hA0 + k, 4'hF, 3'd2);
        end
        check("fill_ready_full", {31'b0, req_ready}, 32'd0);
        req_addr = 32'h1000_0010; req_data = 32'hA4; req_strb = 4'hF; req_size = 3'd2;
        req_valid = 1'b1;
        step(2);
        check("fill_ready_held", {31'b0, req_ready}, 32'd0);
        check("fill_head_awaddr", awaddr, exp_a[0]);
        check("fill_head_awvalid", {31'b0, awvalid}, 32'd1);
        exp_a[0] = 32'h1000_0004; exp_a[1] = 32'h1000_0008;
        exp_a[2] = 32'h1000_000C; exp_a[3] = 32'h1000_0010;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        n = 0; pops = 0; drop = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (drop) begin
                req_valid = 1'b0;
                drop = 1'b0;
            end
            if (awvalid) begin
                if (n < 4) check("drain_order", awaddr, exp_a[n]);
                else check("drain_extra_aw", 32'd1, 32'd0);
                n++;
            end
            if (bready) pops++;
            if (req_valid && req_ready) begin
                check("fifth_after_first_pop", pops, 32'd1);
                drop = 1'b1;
            end
        end
        check("drain_count", n, 32'd4);
        check("drain_fifth_taken", {31'b0, req_valid}, 32'd0);
        check("drain_empty", {31'b0, empty}, 32'd1);

        // W before AW, then AW before W
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        base_aw = aw_hs; base_w = w_hs;
        push(32'h2000_0010, 32'h1234_5678, 4'hF, 3'd2);
        step();
        check("ord1_launch", {31'b0, awvalid}, 32'd1);
        wready = 1'b1;
        step();
        check("ord1_wvalid_drop", {31'b0, wvalid}, 32'd0);
        check("ord1_awvalid_hold", {31'b0, awvalid}, 32'd1);
        check("ord1_bready_early", {31'b0, bready}, 32'd0);
        step(2);
        check("ord1_bready_wait", {31'b0, bready}, 32'd0);
        awready = 1'b1;
        step();
        check("ord1_awvalid_drop", {31'b0, awvalid}, 32'd0);
        check("ord1_bready", {31'b0, bready}, 32'd1);
        check("ord1_aw_beats", aw_hs - base_aw, 32'd1);
        check("ord1_w_beats", w_hs - base_w, 32'd1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        step();
        check("ord1_empty", {31'b0, empty}, 32'd1);
        bvalid = 1'b0;
        base_aw = aw_hs; base_w = w_hs;
        push(32'h2000_0020, 32'h8765_4321, 4'h3, 3'd1);
        step();
        awready = 1'b1;
        step();
        check("ord2_awvalid_drop", {31'b0, awvalid}, 32'd0);
        check("ord2_wvalid_hold", {31'b0, wvalid}, 32'd1);
        check("ord2_bready_early", {31'b0, bready}, 32'd0);
        step(2);
        check("ord2_bready_wait", {31'b0, bready}, 32'd0);
        wready = 1'b1;
        step();
        check("ord2_wvalid_drop", {31'b0, wvalid}, 32'd0);
        check("ord2_bready", {31'b0, bready}, 32'd1);
        check("ord2_aw_beats", aw_hs - base_aw, 32'd1);
        check("ord2_w_beats", w_hs - base_w, 32'd1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        step();
        check("ord2_empty", {31'b0, empty}, 32'd1);
        bvalid = 1'b0;

        // Address check against pending entries
        push(32'h1FD0_0004, 32'h5555_AAAA, 4'hF, 3'd2);
        chk_addr = 32'h1FD0_0006;
        #1 check("chk_same_word", {31'b0, chk_hit}, 32'd1);
        chk_addr = 32'h1FD0_0008;
        #1 check("chk_next_word", {31'b0, chk_hit}, 32'd0);
        chk_addr = 32'h1FD0_0006;
        awready = 1'b1; wready = 1'b1;
        step(2);
        check("chk_resp_bready", {31'b0, bready}, 32'd1);
        check("chk_hit_in_resp", {31'b0, chk_hit}, 32'd1);
        bvalid = 1'b1;
        step();
        check("chk_after_pop", {31'b0, chk_hit}, 32'd0);
        check("chk_empty", {31'b0, empty}, 32'd1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        // Asynchronous reset while a transfer is in flight
        push(32'h1FAF_F100, 32'hCAFE_F00D, 4'hF, 3'd2);
        step();
        check("rst2_launch", {31'b0, awvalid}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("rst2_awvalid", {31'b0, awvalid}, 32'd0);
        check("rst2_wvalid", {31'b0, wvalid}, 32'd0);
        check("rst2_bready", {31'b0, bready}, 32'd0);
        step();
        aresetn = 1'b1;
        step();
        check("rst2_empty", {31'b0, empty}, 32'd1);
        check("rst2_req_ready", {31'b0, req_ready}, 32'd1);

`ifdef WBUF_MERGE_EN
        // Merge into a non-launched tail entry
        push(32'h1FAF_F010, 32'h0000_0011, 4'h1, 3'd0);
        step();
        push(32'h1FAF_F010, 32'h0000_2200, 4'h2, 3'd0);
        push(32'h1FAF_F010, 32'h0033_0000, 4'h4, 3'd0);
        check("mrg_head_wstrb", {28'b0, wstrb}, 32'h1);
        check("mrg_head_wdata", wdata, 32'h0000_0011);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (awvalid) begin
                check("mrg_e1_awaddr", awaddr, 32'h1FAF_F010);
                check("mrg_e1_wstrb", {28'b0, wstrb}, 32'h6);
                check("mrg_e1_wdata", wdata, 32'h0033_2200);
                n++;
            end
        end
        check("mrg_entry_count", n, 32'd1);
        check("mrg_empty", {31'b0, empty}, 32'd1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
